// File: rtl/washer_status_if.sv
// Status bundle between the washer controller and its passive monitor.
// The controller side (master) drives the phase flags and lid switch; the
// monitor side (slave) observes them and publishes decoded status.
interface washer_status_if;
  logic        i_idle;
  logic        i_ready;
  logic        i_soak;
  logic        i_wash;
  logic        i_rinse;
  logic        i_spin;
  logic        i_done;
  logic        i_lid;

  logic [2:0]  o_phase;
  logic [11:0] o_phase_sec;
  logic [12:0] o_total_sec;
  logic        o_buzzer;
  logic [7:0]  o_cycles;
  logic        o_err_onehot;
  logic        o_err_seq;
  logic        o_err_timeout;

  modport master (
    output i_idle, i_ready, i_soak, i_wash, i_rinse, i_spin, i_done, i_lid,
    input  o_phase, o_phase_sec, o_total_sec, o_buzzer, o_cycles,
           o_err_onehot, o_err_seq, o_err_timeout
  );

  modport slave (
    input  i_idle, i_ready, i_soak, i_wash, i_rinse, i_spin, i_done, i_lid,
    output o_phase, o_phase_sec, o_total_sec, o_buzzer, o_cycles,
           o_err_onehot, o_err_seq, o_err_timeout
  );
endinterface

// File: rtl/washer_status_monitor.sv
// Passive washer status monitor: decodes the one-hot phase flags, times each
// phase and the whole cycle (frozen while the lid is open), flags multi-hot
// inputs, illegal phase order and stuck phases, and runs the end-of-cycle
// buzzer. It only observes the controller and never drives it.
module washer_status_monitor #(
  parameter int unsigned CLK_HZ        = 250,
  parameter int unsigned BUZZ_SEC      = 3,
  parameter int unsigned MAX_PHASE_SEC = 1800
) (
  input  logic            i_clk,
  input  logic            i_rst,
  washer_status_if.slave  bus
);

  localparam int unsigned PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BUZZ_LOAD = BUZZ_SEC * CLK_HZ;
  localparam int unsigned BUZZ_W    = (BUZZ_LOAD > 1) ? $clog2(BUZZ_LOAD + 1) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [BUZZ_W-1:0]  BUZZ_INIT  = BUZZ_W'(BUZZ_LOAD);
  localparam logic [11:0]        WDOG_SEC   = 12'(MAX_PHASE_SEC);

  typedef enum logic [2:0] {
    PH_NONE  = 3'd0,
    PH_IDLE  = 3'd1,
    PH_READY = 3'd2,
    PH_SOAK  = 3'd3,
    PH_WASH  = 3'd4,
    PH_RINSE = 3'd5,
    PH_SPIN  = 3'd6,
    PH_DONE  = 3'd7
  } phase_e;

  // Registered state
  phase_e              r_phase;
  logic [PRESC_W-1:0]  r_presc;
  logic [11:0]         r_phase_sec;
  logic [12:0]         r_total_sec;
  logic                r_buzzer;
  logic [BUZZ_W-1:0]   r_buzz_cnt;
  logic [7:0]          r_cycles;
  logic                r_err_onehot;
  logic                r_err_seq;
  logic                r_err_timeout;

  // Next-state values
  phase_e              w_phase_nxt;
  logic [PRESC_W-1:0]  w_presc_nxt;
  logic [11:0]         w_phase_sec_nxt;
  logic [12:0]         w_total_sec_nxt;
  logic                w_buzzer_nxt;
  logic [BUZZ_W-1:0]   w_buzz_cnt_nxt;
  logic [7:0]          w_cycles_nxt;
  logic                w_err_onehot_nxt;
  logic                w_err_seq_nxt;
  logic                w_err_timeout_nxt;

  // Decode helpers
  logic [6:0]          w_flags;
  logic                w_multi;
  phase_e              w_decoded;
  logic                w_change;
  logic                w_active;
  logic                w_legal;
  logic                w_clear_total;
  logic                w_count_en;
  logic [PRESC_W-1:0]  w_presc_inc;
  logic                w_tick;

  // Active washing phases are the ones that are timed and watchdogged.
  function automatic logic is_active(input phase_e ph);
    return (ph >= PH_SOAK) && (ph <= PH_SPIN);
  endfunction

  // Phase-order rules: forward through the wash ranks, cancel to idle,
  // restart from done, and dropping to "no flag" is always allowed.
  function automatic logic is_legal(input phase_e from_ph, input phase_e to_ph);
    logic ok;
    ok = 1'b0;
    if (from_ph == PH_NONE || to_ph == PH_NONE) begin
      ok = 1'b1;
    end else begin
      case (from_ph)
        PH_IDLE:  ok = (to_ph == PH_READY);
        PH_READY: ok = (to_ph == PH_SOAK) || (to_ph == PH_WASH) || (to_ph == PH_IDLE);
        PH_DONE:  ok = (to_ph == PH_IDLE) || (to_ph == PH_READY);
        default:  ok = (to_ph > from_ph) || (to_ph == PH_IDLE);
      endcase
    end
    return ok;
  endfunction

  // Flag decode, transition classification and prescaler arithmetic.
  always_comb begin
    w_flags = {bus.i_done, bus.i_spin, bus.i_rinse, bus.i_wash,
               bus.i_soak, bus.i_ready, bus.i_idle};
    w_multi = |(w_flags & (w_flags - 7'd1));

    w_decoded = PH_NONE;
    for (int i = 0; i < 7; i++) begin
      if (w_flags[i]) w_decoded = phase_e'(3'(i + 1));
    end

    w_change   = !w_multi && (w_decoded != r_phase);
    w_active   = is_active(r_phase);
    w_legal    = is_legal(r_phase, w_decoded);

    w_clear_total = ((r_phase == PH_READY) &&
                     ((w_decoded == PH_SOAK) || (w_decoded == PH_WASH))) ||
                    (w_active && (w_decoded == PH_IDLE));

    // Time only runs in a settled active phase with the lid shut; a
    // multi-hot sample freezes everything for that cycle.
    w_count_en  = !w_multi && !w_change && w_active && !bus.i_lid;
    w_presc_inc = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
    // A second is credited on the edge the prescaler reaches its terminal
    // count, so a phase held for N full seconds shows N before it ends.
    w_tick      = (w_presc_inc == PRESC_LAST);
  end

  // Next-state computation for phase, timers, counters, errors and buzzer.
  always_comb begin
    w_phase_nxt       = r_phase;
    w_presc_nxt       = r_presc;
    w_phase_sec_nxt   = r_phase_sec;
    w_total_sec_nxt   = r_total_sec;
    w_buzzer_nxt      = r_buzzer;
    w_buzz_cnt_nxt    = r_buzz_cnt;
    w_cycles_nxt      = r_cycles;
    w_err_onehot_nxt  = r_err_onehot | w_multi;
    w_err_seq_nxt     = r_err_seq;
    w_err_timeout_nxt = r_err_timeout;

    if (w_change) begin
      w_phase_nxt     = w_decoded;
      w_presc_nxt     = '0;
      w_phase_sec_nxt = '0;
      if (!w_legal)      w_err_seq_nxt   = 1'b1;
      if (w_clear_total) w_total_sec_nxt = '0;
      if (w_decoded == PH_DONE) w_cycles_nxt = r_cycles + 8'd1;
    end else if (w_count_en) begin
      w_presc_nxt = w_presc_inc;
      if (w_tick) begin
        if (r_phase_sec != '1) w_phase_sec_nxt = r_phase_sec + 12'd1;
        if (r_total_sec != '1) w_total_sec_nxt = r_total_sec + 13'd1;
      end
    end

    // Watchdog looks at the registered count; counting carries on after.
    if (w_active && (r_phase_sec == WDOG_SEC)) w_err_timeout_nxt = 1'b1;

    // Buzzer runs on wall-clock time, independent of the lid.
    if (w_change && (w_decoded == PH_DONE)) begin
      w_buzz_cnt_nxt = BUZZ_INIT;
      w_buzzer_nxt   = (BUZZ_LOAD != 0);
    end else if (w_change && (r_phase == PH_DONE)) begin
      w_buzz_cnt_nxt = '0;
      w_buzzer_nxt   = 1'b0;
    end else if (r_buzz_cnt != '0) begin
      w_buzz_cnt_nxt = r_buzz_cnt - 1'b1;
      w_buzzer_nxt   = (r_buzz_cnt != BUZZ_W'(1));
    end
  end

  // State register with synchronous reset; reset discards all timing.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the same pre-edge values computed above.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase       <= PH_NONE;
      r_presc       <= '0;
      r_phase_sec   <= '0;
      r_total_sec   <= '0;
      r_buzzer      <= 1'b0;
      r_buzz_cnt    <= '0;
      r_cycles      <= '0;
      r_err_onehot  <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_presc       <= w_presc_nxt;
      r_phase_sec   <= w_phase_sec_nxt;
      r_total_sec   <= w_total_sec_nxt;
      r_buzzer      <= w_buzzer_nxt;
      r_buzz_cnt    <= w_buzz_cnt_nxt;
      r_cycles      <= w_cycles_nxt;
      r_err_onehot  <= w_err_onehot_nxt;
      r_err_seq     <= w_err_seq_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign bus.o_phase       = r_phase;
  assign bus.o_phase_sec   = r_phase_sec;
  assign bus.o_total_sec   = r_total_sec;
  assign bus.o_buzzer      = r_buzzer;
  assign bus.o_cycles      = r_cycles;
  assign bus.o_err_onehot  = r_err_onehot;
  assign bus.o_err_seq     = r_err_seq;
  assign bus.o_err_timeout = r_err_timeout;

endmodule
